multi_chan_edge_seq: RTL and testbench
======================================

Name: multi_chan_edge_seq

Overview:
- Parametrised multi-channel successor to the single-state per-edge sequencer.
- One state machine per channel, driven by one bit of an enable vector. Each channel detects a rising enable, qualifies it with data, fires a one-cycle strobe, holds off for a programmable time, and keeps a saturating event count.
- A run-time selector routes one channel's strobe to a shared output.
- Sits between clock-enable generation logic and downstream capture/display logic in the regression design.

Parameters:
- NCH, 4, number of channels (1..16).
- CNT_W, 4, width of each per-channel event counter (2..8).
- HOLD_CYC, 3, hold-off cycles after a fire (1..2**CNT_W-1).
- SEL_W, $clog2(NCH) (min 1), derived width of the selector; do not override.

Ports:
- i_clk  in  1  sole clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset. Asserts asynchronously; release is synchronised by the integrator.
- i_ens  in  NCH  per-channel enable level; bit k drives channel k.
- i_data  in  NCH  per-channel qualify bit, sampled in ARM.
- i_clr  in  1  synchronous clear of all counters, states and the error flag.
- i_sel  in  SEL_W  channel routed to o_sel_fire.
- o_state  out  2*NCH  channel k state at [2k+1:2k].
- o_fire  out  NCH  registered one-cycle fire strobe per channel.
- o_cnt  out  CNT_W*NCH  channel k event count at [CNT_W*(k+1)-1:CNT_W*k].
- o_sel_fire  out  1  o_fire[i_sel]; 0 if i_sel >= NCH.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset (i_rst_n=0, async) sets:
  - all states IDLE (2'b00);
  - o_fire=0, o_cnt=0, o_err=0;
  - en_q (registered i_ens) = 0;
  - hold counters = 0.
- Edge detect per channel: rise_k = i_ens[k] & ~en_q[k]. en_q updates every cycle.
- Channel FSM transitions, per cycle:
  - IDLE (00): rise_k -> ARM.
  - ARM (01):
    - i_data[k]=1 -> FIRE;
    - else if i_ens[k]=0 -> IDLE;
    - else stay in ARM.
  - FIRE (10):
    - o_fire[k]=1 for exactly this one registered cycle;
    - o_cnt[k] += 1, saturating at 2**CNT_W-1 with no wrap;
    - hold counter loaded with HOLD_CYC;
    - next state HOLD.
  - HOLD (11): hold counter decrements each cycle. At 1 -> IDLE. Edges during HOLD are ignored; en_q still tracks.
- Timing: from the rise sample with i_data=1 already high, o_fire asserts 2 cycles later (IDLE->ARM, ARM->FIRE). The next fire can occur no earlier than HOLD_CYC+3 cycles after the previous one.
- o_fire is a decode of the registered FIRE state, so there is no combinational path from inputs to o_fire.
- o_sel_fire is a combinational mux of o_fire by i_sel; it is the only comb path.
- i_sel >= NCH (non-power-of-2 NCH): o_sel_fire=0 and o_err is set on the next edge, sticky.
- o_err is also set if any channel's hold counter is nonzero while that channel is in IDLE/ARM (internal consistency check).
- i_clr=1:
  - all channels -> IDLE; counters, hold counters and o_err -> 0; o_fire=0 next cycle;
  - clr wins over a simultaneous fire or increment;
  - en_q still updates, so a level held high across clr does not re-trigger.
- Channels are fully independent; simultaneous fires on all channels are legal.
- Reset mid-HOLD or mid-FIRE returns that channel to IDLE immediately and asynchronously.

Decomposition:
- Package multi_chan_edge_seq_pkg holds:
  - typedef enum logic [1:0] chan_state_e {IDLE, ARM, FIRE, HOLD};
  - localparam helper function for the saturating increment.
- Sub-module edge_seq_chan holds one channel (FSM, hold counter, event counter). Ports: clock, reset, en, en_q-based rise, data, clr, state, fire, cnt, err_local.
- Top generates NCH instances, the selector mux and the sticky error OR-reduce.

Test Plan:
1. Reset, then i_ens[0] 0->1 with i_data[0]=1 held -> o_state[1:0] goes 01 then 10; o_fire[0]=1 exactly once, 2 cycles after rise; o_cnt[3:0]=1; back to IDLE after 3 HOLD cycles.
2. Channel 1: rise with i_data[1]=0, then drop i_ens[1] -> ARM then IDLE; o_fire[1] never asserts; o_cnt[1]=0.
3. Channel 2 toggled 20 times at spacing >= HOLD_CYC+3 with data=1 -> o_cnt[2] saturates at 15 and stays 15; no wrap to 0.
4. All four channels rise on the same cycle with data=1 -> o_fire=4'b1111 on one cycle; each o_cnt = 1; o_sel_fire follows i_sel=2 -> 1.
5. i_clr asserted on the FIRE cycle of channel 0 -> next cycle o_fire[0]=0, o_cnt=0, state IDLE; the enable held high does not re-fire.
6. NCH=3 build, i_sel=3 -> o_sel_fire=0 and o_err=1 the next cycle, staying 1 until i_clr. Async i_rst_n pulse mid-HOLD -> all outputs 0 immediately.

Source files
------------

// File: rtl/multi_chan_edge_seq_pkg.sv
// Shared types and helpers for the multi-channel edge sequencer.
// The saturating increment works on a fixed 8-bit container; callers cast to their own width.
package multi_chan_edge_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    FIRE = 2'b10,
    HOLD = 2'b11
  } chan_state_e;

  localparam int unsigned MaxCntW = 8;

  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] val,
                                                 input logic [MaxCntW-1:0] max_val);
    return (val >= max_val) ? max_val : val + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/edge_seq_chan.sv
// One sequencer channel: arm on a rising enable, fire when qualified by data,
// then hold off for HOLD_CYC cycles while keeping a saturating event count.
module edge_seq_chan
  import multi_chan_edge_seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned HOLD_CYC = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             rise_i,
  input  logic             data_i,
  input  logic             clr_i,
  output logic [1:0]       state_o,
  output logic             fire_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_local_o
);

  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYC);

  chan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else if (clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_i) state_q <= ARM;
        end
        ARM: begin
          if (data_i) begin
            state_q <= FIRE;
          end else if (!en_i) begin
            state_q <= IDLE;
          end
        end
        FIRE: begin
          // The count is committed on leaving FIRE so a clear in the FIRE cycle suppresses it.
          cnt_q   <= CNT_W'(sat_inc(MaxCntW'(cnt_q), MaxCntW'(CntMax)));
          hold_q  <= HoldLoad;
          state_q <= HOLD;
        end
        HOLD: begin
          if (hold_q <= CNT_W'(1)) begin
            hold_q  <= '0;
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o     = state_q;
  assign fire_o      = (state_q == FIRE);
  assign cnt_o       = cnt_q;
  assign err_local_o = ((state_q == IDLE) || (state_q == ARM)) && (hold_q != '0);

endmodule

// File: rtl/multi_chan_edge_seq.sv
// NCH independent edge sequencers with a shared edge-detect register, a
// run-time strobe selector and a sticky error flag.
module multi_chan_edge_seq
  import multi_chan_edge_seq_pkg::*;
#(
  parameter  int unsigned NCH      = 4,
  parameter  int unsigned CNT_W    = 4,
  parameter  int unsigned HOLD_CYC = 3,
  localparam int unsigned SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NCH-1:0]       i_ens,
  input  logic [NCH-1:0]       i_data,
  input  logic                 i_clr,
  input  logic [SEL_W-1:0]     i_sel,
  output logic [2*NCH-1:0]     o_state,
  output logic [NCH-1:0]       o_fire,
  output logic [CNT_W*NCH-1:0] o_cnt,
  output logic                 o_sel_fire,
  output logic                 o_err
);

  logic [NCH-1:0] en_q;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] err_local;
  logic           err_q;
  logic           sel_fire;
  logic           sel_ok;

  assign rise = i_ens & ~en_q;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    edge_seq_chan #(
      .CNT_W   (CNT_W),
      .HOLD_CYC(HOLD_CYC)
    ) u_chan (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .en_i       (i_ens[k]),
      .rise_i     (rise[k]),
      .data_i     (i_data[k]),
      .clr_i      (i_clr),
      .state_o    (o_state[2*k +: 2]),
      .fire_o     (o_fire[k]),
      .cnt_o      (o_cnt[CNT_W*k +: CNT_W]),
      .err_local_o(err_local[k])
    );
  end

  // Selectors past the last channel (non-power-of-two NCH) route nothing and flag an error.
  always_comb begin
    sel_fire = 1'b0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (i_sel == SEL_W'(k)) begin
        sel_fire = o_fire[k];
        sel_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q  <= '0;
      err_q <= 1'b0;
    end else begin
      en_q <= i_ens;
      if (i_clr) begin
        err_q <= 1'b0;
      end else if (!sel_ok || (|err_local)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_sel_fire = sel_fire;
  assign o_err      = err_q;

endmodule

// File: tb/tb_multi_chan_edge_seq.sv
// Randomised and directed bench for multi_chan_edge_seq against a timestamp-based reference model.
module tb_multi_chan_edge_seq;

  localparam int unsigned NCH      = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned HOLD_CYC = 3;
  localparam int          CntMax   = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ens, data;
  logic        clr;
  logic [1:0]  sel;
  logic [7:0]  state;
  logic [3:0]  fire;
  logic [15:0] cnt;
  logic        sel_fire, err;

  logic [2:0]  ens3, data3;
  logic        clr3;
  logic [1:0]  sel3;
  logic [5:0]  state3;
  logic [2:0]  fire3;
  logic [11:0] cnt3;
  logic        sel_fire3, err3;

  always #5 clk = ~clk;

  multi_chan_edge_seq #(
    .NCH(NCH), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ens(ens), .i_data(data), .i_clr(clr), .i_sel(sel),
    .o_state(state), .o_fire(fire), .o_cnt(cnt), .o_sel_fire(sel_fire), .o_err(err)
  );

  multi_chan_edge_seq #(
    .NCH(3), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)
  ) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ens(ens3), .i_data(data3), .i_clr(clr3), .i_sel(sel3),
    .o_state(state3), .o_fire(fire3), .o_cnt(cnt3), .o_sel_fire(sel_fire3), .o_err(err3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: each channel is described by the cycle it last fired, whether it is
  // waiting for data, its event count and the previous enable level.
  int cyc;
  int last_fire [NCH];
  bit armed     [NCH];
  int ev_cnt    [NCH];
  bit prev_en   [NCH];

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < NCH; k++) begin
      last_fire[k] = -100;
      armed[k]     = 1'b0;
      ev_cnt[k]    = 0;
      prev_en[k]   = 1'b0;
    end
  endtask

  function automatic logic [1:0] exp_state(input int k);
    if (cyc == last_fire[k]) return 2'd2;
    if (cyc > last_fire[k] && cyc <= last_fire[k] + int'(HOLD_CYC)) return 2'd3;
    if (armed[k]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      bit busy;
      busy = (cyc >= last_fire[k]) && (cyc <= last_fire[k] + int'(HOLD_CYC));
      if (clr) begin
        armed[k] = 1'b0;
        last_fire[k] = -100;
        ev_cnt[k] = 0;
      end else if (busy) begin
        if (cyc == last_fire[k] && ev_cnt[k] < CntMax) ev_cnt[k]++;
      end else if (armed[k]) begin
        if (data[k]) begin
          last_fire[k] = cyc + 1;
          armed[k] = 1'b0;
        end else if (!ens[k]) begin
          armed[k] = 1'b0;
        end
      end else if (ens[k] && !prev_en[k]) begin
        armed[k] = 1'b1;
      end
      prev_en[k] = ens[k];
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [7:0]  es;
    logic [3:0]  ef;
    logic [15:0] ec;
    for (int k = 0; k < NCH; k++) begin
      es[2*k +: 2] = exp_state(k);
      ef[k]        = (cyc == last_fire[k]);
      ec[4*k +: 4] = 4'(ev_cnt[k]);
    end
    check_eq("state", 32'(state), 32'(es));
    check_eq("fire", 32'(fire), 32'(ef));
    check_eq("cnt", 32'(cnt), 32'(ec));
    check_eq("err", 32'(err), 32'd0);
  endtask

  task automatic step(input logic [3:0] e, input logic [3:0] d, input logic c,
                      input logic [1:0] s);
    ens = e; data = d; clr = c; sel = s;
    #1;
    check_eq("sel_fire", 32'(sel_fire), 32'(cyc == last_fire[s]));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    ens = '0; data = '0; clr = 1'b0; sel = '0;
    ens3 = '0; data3 = '0; clr3 = 1'b0; sel3 = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_fire", 32'(fire), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_err3", 32'(err3), 32'd0);
    rst_n = 1'b1;

    // 1: fire two cycles after the rise, then three hold cycles.
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t1_arm", 32'(state[1:0]), 32'd1);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t1_fire", 32'(fire[0]), 32'd1);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t1_cnt", 32'(cnt[3:0]), 32'd1);
    check_eq("t1_fire_off", 32'(fire[0]), 32'd0);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t1_hold", 32'(state[1:0]), 32'd3);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t1_idle", 32'(state[1:0]), 32'd0);

    // 2: unqualified rise on channel 1 drops back to idle.
    step(4'b0011, 4'b0001, 1'b0, 2'd1);
    check_eq("t2_arm", 32'(state[3:2]), 32'd1);
    step(4'b0001, 4'b0001, 1'b0, 2'd1);
    check_eq("t2_idle", 32'(state[3:2]), 32'd0);
    check_eq("t2_cnt", 32'(cnt[7:4]), 32'd0);

    // 3: channel 2 fired 20 times saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, 4'b0100, 1'b0, 2'd2);
      repeat (HOLD_CYC + 2) step(4'b0000, 4'b0100, 1'b0, 2'd2);
    end
    check_eq("t3_sat", 32'(cnt[11:8]), 32'd15);

    // 4: all channels fire together.
    step(4'b0000, 4'b0000, 1'b1, 2'd2);
    step(4'b0000, 4'b0000, 1'b0, 2'd2);
    step(4'b1111, 4'b1111, 1'b0, 2'd2);
    step(4'b1111, 4'b1111, 1'b0, 2'd2);
    check_eq("t4_fire_all", 32'(fire), 32'hf);
    check_eq("t4_sel_fire", 32'(sel_fire), 32'd1);
    step(4'b1111, 4'b1111, 1'b0, 2'd2);
    check_eq("t4_cnt", 32'(cnt), 32'h1111);
    repeat (4) step(4'b0000, 4'b0000, 1'b0, 2'd0);

    // 5: clear in the FIRE cycle wins; held enable does not re-trigger.
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t5_fire", 32'(fire[0]), 32'd1);
    step(4'b0001, 4'b0001, 1'b1, 2'd0);
    check_eq("t5_clr_fire", 32'(fire[0]), 32'd0);
    check_eq("t5_clr_cnt", 32'(cnt), 32'd0);
    check_eq("t5_clr_state", 32'(state), 32'd0);
    repeat (3) step(4'b0001, 4'b0001, 1'b0, 2'd0);
    check_eq("t5_no_refire", 32'(state[1:0]), 32'd0);

    // Asynchronous reset while channel 1 is in HOLD.
    step(4'b0000, 4'b0010, 1'b0, 2'd1);
    step(4'b0010, 4'b0010, 1'b0, 2'd1);
    step(4'b0010, 4'b0010, 1'b0, 2'd1);
    step(4'b0010, 4'b0010, 1'b0, 2'd1);
    check_eq("rst_pre_hold", 32'(state[3:2]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_fire", 32'(fire), 32'd0);
    check_eq("arst_cnt", 32'(cnt), 32'd0);
    model_reset();
    ens = '0;
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] e;
      e = ens ^ (4'($urandom) & 4'($urandom));
      step(e, 4'($urandom), ($urandom_range(0, 63) == 0), 2'($urandom));
    end

    // 6: out-of-range selector on a three-channel build.
    ens3 = 3'b111; data3 = 3'b111;
    repeat (2) @(posedge clk);
    sel3 = 2'd3;
    #1;
    check_eq("t6_fire3", 32'(fire3), 32'h7);
    check_eq("t6_sel_fire", 32'(sel_fire3), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_err_set", 32'(err3), 32'd1);
    sel3 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_err_sticky", 32'(err3), 32'd1);
    clr3 = 1'b1;
    @(posedge clk);
    #1;
    clr3 = 1'b0;
    check_eq("t6_err_clr", 32'(err3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
